// File: rtl/tile_render_scheduler.sv
// rtl/tile_render_scheduler.sv - raster-order tile launcher that packs SM pixel rows into a tile word
// Optional feature macro: TILE_SCHED_AUTO_RESTART_EN (restart at tile 0,0 after each frame).
module tile_render_scheduler #(
    parameter int TILES_X  = 40,
    parameter int TILES_Y  = 30,
    parameter int TILE_DIM = 16,
    parameter int PIX_W    = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i_frame_start,
    output logic                                 o_sm_tile_start,
    input  logic                                 i_sm_row_valid,
    input  logic [TILE_DIM*PIX_W-1:0]            i_sm_row_data,
    output logic [5:0]                           o_current_tile_x,
    output logic [5:0]                           o_current_tile_y,
    output logic                                 o_sm_render_done,
    output logic [TILE_DIM*TILE_DIM*PIX_W-1:0]   o_sm_color_data,
    output logic                                 o_frame_done,
    output logic                                 o_busy
);

    localparam int ROW_W = TILE_DIM * PIX_W;
    localparam int RC_W  = $clog2(TILE_DIM);

    localparam logic [5:0]      X_LAST   = 6'(TILES_X - 1);
    localparam logic [5:0]      Y_LAST   = 6'(TILES_Y - 1);
    localparam logic [RC_W-1:0] ROW_LAST = RC_W'(TILE_DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_GATHER,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [5:0]                         tile_x;
    logic [5:0]                         tile_y;
    logic [RC_W-1:0]                    row_cnt;
    logic                               frame_wrap;
    logic [TILE_DIM*TILE_DIM*PIX_W-1:0] color_data;
    logic                               last_row;

    assign last_row = (state == S_GATHER) && i_sm_row_valid && (row_cnt == ROW_LAST);

    // Coordinates advance on the edge that accepts the last row, so DONE already shows the next tile.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            tile_x     <= '0;
            tile_y     <= '0;
            row_cnt    <= '0;
            frame_wrap <= 1'b0;
            color_data <= '0;
        end else begin
            state <= state_next;
            if (state == S_LAUNCH) begin
                row_cnt <= '0;
            end
            if (state == S_GATHER && i_sm_row_valid) begin
                color_data[row_cnt*ROW_W +: ROW_W] <= i_sm_row_data;
                row_cnt <= row_cnt + RC_W'(1);
            end
            if (last_row) begin
                frame_wrap <= (tile_x == X_LAST) && (tile_y == Y_LAST);
                if (tile_x == X_LAST) begin
                    tile_x <= '0;
                    tile_y <= (tile_y == Y_LAST) ? '0 : tile_y + 6'd1;
                end else begin
                    tile_x <= tile_x + 6'd1;
                end
            end
        end
    end

    always_comb begin
        state_next       = state;
        o_sm_tile_start  = 1'b0;
        o_sm_render_done = 1'b0;
        o_frame_done     = 1'b0;
        o_busy           = 1'b1;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_frame_start) begin
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                o_sm_tile_start = 1'b1;
                state_next      = S_GATHER;
            end
            S_GATHER: begin
                if (last_row) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_sm_render_done = 1'b1;
                o_frame_done     = frame_wrap;
`ifdef TILE_SCHED_AUTO_RESTART_EN
                state_next = S_LAUNCH;
`else
                state_next = frame_wrap ? S_IDLE : S_LAUNCH;
`endif
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign o_current_tile_x = tile_x;
    assign o_current_tile_y = tile_y;
    assign o_sm_color_data  = color_data;

endmodule

// File: tb/tb_tile_render_scheduler.sv
// tb/tb_tile_render_scheduler.sv - randomized self-checking bench for tile_render_scheduler
module tb_tile_render_scheduler;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_frame_start;
    logic          o_sm_tile_start;
    logic          i_sm_row_valid;
    logic [127:0]  i_sm_row_data;
    logic [5:0]    o_current_tile_x;
    logic [5:0]    o_current_tile_y;
    logic          o_sm_render_done;
    logic [2047:0] o_sm_color_data;
    logic          o_frame_done;
    logic          o_busy;

    tile_render_scheduler dut (
        .clk              (clk),
        .reset            (reset),
        .i_frame_start    (i_frame_start),
        .o_sm_tile_start  (o_sm_tile_start),
        .i_sm_row_valid   (i_sm_row_valid),
        .i_sm_row_data    (i_sm_row_data),
        .o_current_tile_x (o_current_tile_x),
        .o_current_tile_y (o_current_tile_y),
        .o_sm_render_done (o_sm_render_done),
        .o_sm_color_data  (o_sm_color_data),
        .o_frame_done     (o_frame_done),
        .o_busy           (o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int fdone_cnt = 0;
    logic [127:0] rows [16];

    always @(negedge clk) begin
        if (o_sm_render_done === 1'b1) done_cnt++;
        if (o_frame_done === 1'b1) fdone_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] row_of(input int r);
        return o_sm_color_data[r*128 +: 128];
    endfunction

    // Entered while the LAUNCH cycle is visible; leaves after DONE (or after stop_after rows mid-GATHER).
    task automatic run_tile(input int x, input int y, input int stop_after, input bit fixed, input int p_valid);
        int acc;
        int k;
        int lin;
        bit v;
        logic [127:0] d;
        check("launch_pulse", o_sm_tile_start, 1);
        check("launch_x", o_current_tile_x, x);
        check("launch_y", o_current_tile_y, y);
        check("launch_busy", o_busy, 1);
        i_sm_row_valid = 1'b1;
        i_sm_row_data  = rand128();
        step();
        acc = 0;
        k = 0;
        while (acc < stop_after) begin
            check("gather_quiet", {o_sm_tile_start, o_sm_render_done, o_frame_done}, 0);
            if (fixed) begin
                v = (k % 3 == 0);
                d = {16{8'(acc)}};
            end else begin
                v = ($urandom_range(0, 99) < p_valid);
                d = rand128();
            end
            i_sm_row_valid = v;
            i_sm_row_data  = d;
            i_frame_start  = ($urandom_range(0, 15) == 0);
            step();
            if (v) begin
                rows[acc] = d;
                acc++;
            end
            k++;
        end
        i_frame_start = 1'b0;
        if (stop_after < 16) return;
        lin = y * 40 + x + 1;
        if (lin == 1200) lin = 0;
        check("done_pulse", o_sm_render_done, 1);
        check("done_frame", o_frame_done, (x == 39 && y == 29) ? 1 : 0);
        check("done_next_x", o_current_tile_x, lin % 40);
        check("done_next_y", o_current_tile_y, lin / 40);
        check("done_no_start", o_sm_tile_start, 0);
        for (int r = 0; r < 16; r++) check("done_row", row_of(r), rows[r]);
        i_sm_row_valid = 1'b1;
        i_sm_row_data  = rand128();
        step();
        i_sm_row_valid = 1'b0;
        check("hold_row0", row_of(0), rows[0]);
        check("hold_row15", row_of(15), rows[15]);
    endtask

    initial begin
        int base_done;
        int base_fdone;
        reset          = 1'b1;
        i_frame_start  = 1'b0;
        i_sm_row_valid = 1'b0;
        i_sm_row_data  = '0;
        repeat (3) step();
        check("rst_busy", o_busy, 0);
        check("rst_pulses", {o_sm_tile_start, o_sm_render_done, o_frame_done}, 0);
        check("rst_x", o_current_tile_x, 0);
        check("rst_y", o_current_tile_y, 0);
        for (int r = 0; r < 16; r++) check("rst_data", row_of(r), 0);

        reset          = 1'b0;
        i_sm_row_valid = 1'b1;
        i_sm_row_data  = rand128();
        step();
        i_sm_row_valid = 1'b0;
        check("idle_ignore_row", row_of(0), 0);
        check("idle_busy", o_busy, 0);

        base_done  = done_cnt;
        base_fdone = fdone_cnt;
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        for (int lin = 0; lin < 1200; lin++) begin
            run_tile(lin % 40, lin / 40, 16, lin == 0, 85);
            if (lin == 0) begin
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++)
                        check("tile0_byte", o_sm_color_data[(r*16+c)*8 +: 8], r);
            end
        end
`ifdef TILE_SCHED_AUTO_RESTART_EN
        check("auto_restart", o_sm_tile_start, 1);
`else
        check("end_idle_busy", o_busy, 0);
        check("end_no_start", o_sm_tile_start, 0);
`endif
        check("frame_done_count", fdone_cnt - base_fdone, 1);
        check("render_done_count", done_cnt - base_done, 1200);
`ifndef TILE_SCHED_AUTO_RESTART_EN
        step();
        check("idle_stays", {o_busy, o_sm_tile_start}, 0);
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
`endif

        for (int lin = 0; lin < 123; lin++) run_tile(lin % 40, lin / 40, 16, 1'b0, 60);
        run_tile(3, 3, 16, 1'b0, 30);
        run_tile(4, 3, 16, 1'b0, 95);
        run_tile(5, 3, 8, 1'b0, 70);
        base_done = done_cnt;
        reset          = 1'b1;
        i_frame_start  = 1'b1;
        i_sm_row_valid = 1'b1;
        i_sm_row_data  = rand128();
        step();
        reset          = 1'b0;
        i_frame_start  = 1'b0;
        i_sm_row_valid = 1'b0;
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_pulses", {o_sm_tile_start, o_sm_render_done, o_frame_done}, 0);
        check("mid_rst_x", o_current_tile_x, 0);
        check("mid_rst_y", o_current_tile_y, 0);
        for (int r = 0; r < 16; r++) check("mid_rst_data", row_of(r), 0);
        step();
        check("rst_beats_start", {o_busy, o_sm_tile_start}, 0);
        check("mid_rst_no_done", done_cnt - base_done, 0);
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        check("restart_pulse", o_sm_tile_start, 1);
        check("restart_xy", {o_current_tile_y, o_current_tile_x}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
